// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory controller.
//
// Contents:
//   size_e      - access size encodings (1, 2, 4 or 8 bytes per access)
//   state_e     - controller FSM state encodings
//   byte_count  - maps an access size encoding to its byte count N (1..8)
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_1B = 2'b00,
        SIZE_2B = 2'b01,
        SIZE_4B = 2'b10,
        SIZE_8B = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RELEASE = 2'b10,
        DONE    = 2'b11
    } state_e;

    function automatic logic [3:0] byte_count(input size_e size);
        logic [3:0] n;
        case (size)
            SIZE_1B: n = 4'd1;
            SIZE_2B: n = 4'd2;
            SIZE_4B: n = 4'd4;
            SIZE_8B: n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller.
//
// A CPU access of 1, 2, 4 or 8 bytes is split into single-byte transfers,
// each one a full four-phase handshake with the memory (raise strobe, wait
// ack high, drop strobe, wait ack low). Bytes go out in ascending address
// order, with the address wrapping modulo 2^MADDR_SZ. Read bytes are
// assembled little-endian and optionally sign-extended.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   req, wr, size,  - CPU request and its attributes, sampled only in IDLE
//   sext, addr,
//   wdata
//   rdata, done     - assembled read data, valid during the one-cycle done pulse
//   busy            - high from request acceptance until the done pulse
//   raddr, re,      - memory read channel (address, strobe, ack, data byte)
//   rack, dataout
//   waddr, we,      - memory write channel (address, strobe, ack, data byte)
//   wack, datain
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int MADDR_SZ = 32,
    parameter int DATA_SZ  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                wr,
    input  logic [1:0]          size,
    input  logic                sext,
    input  logic [MADDR_SZ-1:0] addr,
    input  logic [DATA_SZ-1:0]  wdata,
    output logic [DATA_SZ-1:0]  rdata,
    output logic                done,
    output logic                busy,
    output logic [MADDR_SZ-1:0] raddr,
    output logic [MADDR_SZ-1:0] waddr,
    output logic                re,
    output logic                we,
    output logic [7:0]          datain,
    input  logic [7:0]          dataout,
    input  logic                rack,
    input  logic                wack
);

    localparam int NBYTES = DATA_SZ / 8;

    state_e                state_q,  state_d;
    logic   [2:0]          idx_q,    idx_d;
    logic                  wr_q,     wr_d;
    size_e                 size_q,   size_d;
    logic                  sext_q,   sext_d;
    logic   [MADDR_SZ-1:0] addr_q,   addr_d;
    logic   [DATA_SZ-1:0]  wdata_q,  wdata_d;
    logic   [DATA_SZ-1:0]  rdata_q,  rdata_d;
    logic                  done_q,   done_d;
    logic                  busy_q,   busy_d;
    logic   [MADDR_SZ-1:0] raddr_q,  raddr_d;
    logic   [MADDR_SZ-1:0] waddr_q,  waddr_d;
    logic                  re_q,     re_d;
    logic                  we_q,     we_d;
    logic   [7:0]          datain_q, datain_d;

    logic                  ack;
    logic   [3:0]          last_idx;
    logic   [2:0]          next_idx;
    logic   [MADDR_SZ-1:0] next_addr;

    // Selects byte 'sel' of a little-endian data word.
    function automatic logic [7:0] pick_byte(input logic [DATA_SZ-1:0] data,
                                             input logic [2:0]         sel);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (i == int'(sel)) begin
                b = data[i*8 +: 8];
            end
        end
        return b;
    endfunction

    // Fills every bit above the n-byte field with either the field's top bit
    // (sign_en=1) or zero. Loops keep all bit indices constant after unrolling.
    function automatic logic [DATA_SZ-1:0] extend(input logic [DATA_SZ-1:0] data,
                                                  input logic [3:0]         n,
                                                  input logic               sign_en);
        logic [DATA_SZ-1:0] r;
        logic               sign;
        r    = data;
        sign = 1'b0;
        for (int i = 0; i < DATA_SZ; i++) begin
            if (i == 8 * int'(n) - 1) begin
                sign = data[i];
            end
        end
        for (int i = 0; i < DATA_SZ; i++) begin
            if (i >= 8 * int'(n)) begin
                r[i] = sign_en & sign;
            end
        end
        return r;
    endfunction

    // The handshake only ever watches the ack of the channel in use.
    assign ack       = wr_q ? wack : rack;
    assign last_idx  = byte_count(size_q) - 4'd1;
    assign next_idx  = idx_q + 3'd1;
    assign next_addr = addr_q + MADDR_SZ'(next_idx);

    // Next-state and next-output computation. All outputs are registered, so
    // each branch sets up the strobe/address/data values for the coming cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        size_d   = size_q;
        sext_d   = sext_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        re_d     = re_q;
        we_d     = we_q;
        datain_d = datain_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d     = wr;
                    size_d   = size_e'(size);
                    sext_d   = sext;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    idx_d    = 3'd0;
                    rdata_d  = '0;
                    busy_d   = 1'b1;
                    re_d     = ~wr;
                    we_d     = wr;
                    raddr_d  = addr;
                    waddr_d  = addr;
                    datain_d = wr ? wdata[7:0] : 8'h00;
                    state_d  = ACCESS;
                end
            end

            ACCESS: begin
                if (ack) begin
                    if (!wr_q) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (i == int'(idx_q)) begin
                                rdata_d[i*8 +: 8] = dataout;
                            end
                        end
                    end
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (!ack) begin
                    if ({1'b0, idx_q} == last_idx) begin
                        // Extension is applied once, as the data becomes visible.
                        rdata_d = wr_q ? '0 : extend(rdata_q, byte_count(size_q), sext_q);
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d    = next_idx;
                        raddr_d  = next_addr;
                        waddr_d  = next_addr;
                        datain_d = wr_q ? pick_byte(wdata_q, next_idx) : 8'h00;
                        re_d     = ~wr_q;
                        we_d     = wr_q;
                        state_d  = ACCESS;
                    end
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register for the FSM and every registered output. Reset
    // aborts any in-flight transfer and drops the strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            wr_q     <= 1'b0;
            size_q   <= SIZE_1B;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            datain_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            re_q     <= re_d;
            we_q     <= we_d;
            datain_q <= datain_d;
        end
    end

    assign rdata  = rdata_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign raddr  = raddr_q;
    assign waddr  = waddr_q;
    assign re     = re_q;
    assign we     = we_q;
    assign datain = datain_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking testbench for mem_ctrl.
//
// A four-phase memory responder with a programmable ack delay sits on both
// channels. It logs every completed byte transfer, counts strobe rising
// edges, and flags strobe overlap or address/data movement while a strobe
// is held. Expected values come from a byte-level model of the access rules.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        done;
    logic        busy;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic        re;
    logic        we;
    logic [7:0]  datain;
    logic [7:0]  dataout;
    logic        rack;
    logic        wack;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [256];
    int          rack_delay = 0;
    int          wack_delay = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr_log [$];
    logic [7:0]  wr_data_log [$];
    int          issue_cnt = 0;
    int          overlap_cnt = 0;
    int          unstable_cnt = 0;
    logic        re_prev = 1'b0;
    logic        we_prev = 1'b0;
    logic [31:0] raddr_prev = '0;
    logic [31:0] waddr_prev = '0;
    logic [7:0]  datain_prev = '0;

    mem_ctrl #(.MADDR_SZ(32), .DATA_SZ(64)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .raddr(raddr), .waddr(waddr), .re(re), .we(we), .datain(datain),
        .dataout(dataout), .rack(rack), .wack(wack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack rises once the strobe has been high for the
    // programmed number of cycles and falls together with the strobe.
    assign rack    = re && (re_cnt >= rack_delay);
    assign wack    = we && (we_cnt >= wack_delay);
    assign dataout = mem[raddr[7:0]];

    always @(posedge clk) begin
        re_cnt <= re ? re_cnt + 1 : 0;
        we_cnt <= we ? we_cnt + 1 : 0;
        if (re && rack) rd_log.push_back(raddr);
        if (we && wack) begin
            wr_addr_log.push_back(waddr);
            wr_data_log.push_back(datain);
        end
        if ((re && !re_prev) || (we && !we_prev)) issue_cnt <= issue_cnt + 1;
        if (re && we) overlap_cnt <= overlap_cnt + 1;
        if ((re && re_prev && raddr != raddr_prev) ||
            (we && we_prev && (waddr != waddr_prev || datain != datain_prev)))
            unstable_cnt <= unstable_cnt + 1;
        re_prev     <= re;
        we_prev     <= we;
        raddr_prev  <= raddr;
        waddr_prev  <= waddr;
        datain_prev <= datain;
    end

    // Reference read: N little-endian bytes from ascending wrapped addresses.
    function automatic logic [63:0] model_read(input logic [31:0] a, input int n, input logic sx);
        logic [63:0] v;
        logic [31:0] ba;
        v = '0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            v  = v | (64'(mem[ba[7:0]]) << (8 * i));
        end
        if (sx && n < 8 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    // Drives one request and waits (bounded) for the done pulse. With hold_req
    // the request stays asserted with scrambled attributes while busy.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [63:0] wd, input logic hold_req,
                             output int cyc, output logic [63:0] rd, output logic busy_first,
                             output logic done_after, output logic busy_after, output logic timed_out);
        @(negedge clk);
        wr = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1;
        if (hold_req) begin
            wr = ~w; addr = ~a; wdata = ~wd;
        end else begin
            req = 1'b0;
        end
        cyc = 0; rd = '0; timed_out = 1'b1; busy_first = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy_first = busy;
            if (done) begin
                rd = rdata;
                timed_out = 1'b0;
                break;
            end
        end
        req = 1'b0;
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (re !== 1'b0) begin failures++; $display("[TB] FAIL reset_re: got %0h want 0", re); end
        checks++; if (we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %0h want 0", we); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0h want 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0h want 0", busy); end
        checks++; if (rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %0h want 0", rdata); end
        checks++; if (raddr !== 32'h0 || waddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %0h/%0h want 0/0", raddr, waddr); end
        checks++; if (datain !== 8'h0) begin failures++; $display("[TB] FAIL reset_datain: got %0h want 0", datain); end
        rst = 1'b0;
    endtask

    task automatic test_read8();
        int cyc; logic [63:0] rd; logic bf, da, ba, to; int rs;
        for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'(i + 1);
        rs = rd_log.size();
        do_access(1'b0, 2'b11, 1'b0, 32'h10, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL read8_timeout: got %0d want 0", to); end
        checks++; if (rd !== 64'h0807060504030201) begin failures++; $display("[TB] FAIL read8_rdata: got %016h want 0807060504030201", rd); end
        checks++; if (cyc != 17) begin failures++; $display("[TB] FAIL read8_latency: got %0d want 17", cyc); end
        checks++; if (bf !== 1'b1) begin failures++; $display("[TB] FAIL read8_busy: got %0h want 1", bf); end
        checks++; if (da !== 1'b0 || ba !== 1'b0) begin failures++; $display("[TB] FAIL read8_after: got done=%0h busy=%0h want 0/0", da, ba); end
        checks++; if (rd_log.size() - rs != 8) begin failures++; $display("[TB] FAIL read8_count: got %0d want 8", rd_log.size() - rs); end
        for (int i = 0; i < 8 && rs + i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[rs + i] !== 32'h10 + 32'(i)) begin failures++; $display("[TB] FAIL read8_addr%0d: got %08h want %08h", i, rd_log[rs + i], 32'h10 + 32'(i)); end
        end
    endtask

    task automatic test_write4();
        int cyc; logic [63:0] rd; logic bf, da, ba, to; int ws;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        ws = wr_addr_log.size();
        do_access(1'b1, 2'b10, 1'b0, 32'h205, 64'h1122_3344_DEAD_BEEF, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL write4_timeout: got %0d want 0", to); end
        checks++; if (rd !== 64'h0) begin failures++; $display("[TB] FAIL write4_rdata: got %0h want 0", rd); end
        checks++; if (cyc != 9) begin failures++; $display("[TB] FAIL write4_latency: got %0d want 9", cyc); end
        checks++; if (wr_addr_log.size() - ws != 4) begin failures++; $display("[TB] FAIL write4_count: got %0d want 4", wr_addr_log.size() - ws); end
        for (int i = 0; i < 4 && ws + i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[ws + i] !== 32'h205 + 32'(i) || wr_data_log[ws + i] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL write4_byte%0d: got %08h:%02h want %08h:%02h", i, wr_addr_log[ws + i], wr_data_log[ws + i], 32'h205 + 32'(i), exp_b[i]);
            end
        end
    endtask

    task automatic test_sext();
        int cyc; logic [63:0] rd; logic bf, da, ba, to;
        mem[8'h40] = 8'h80;
        do_access(1'b0, 2'b00, 1'b1, 32'h40, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80 || to) begin failures++; $display("[TB] FAIL sext_on: got %016h want ffffffffffffff80", rd); end
        checks++; if (cyc != 3) begin failures++; $display("[TB] FAIL sext_latency: got %0d want 3", cyc); end
        do_access(1'b0, 2'b00, 1'b0, 32'h40, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (rd !== 64'h80 || to) begin failures++; $display("[TB] FAIL sext_off: got %016h want 80", rd); end
        mem[8'h50] = 8'h34; mem[8'h51] = 8'hA2; mem[8'h52] = 8'h00; mem[8'h53] = 8'h00;
        do_access(1'b0, 2'b01, 1'b1, 32'h50, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (rd !== 64'hFFFF_FFFF_FFFF_A234 || to) begin failures++; $display("[TB] FAIL sext_half: got %016h want ffffffffffffa234", rd); end
    endtask

    task automatic test_wrap();
        int cyc; logic [63:0] rd; logic bf, da, ba, to; int rs;
        mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
        rs = rd_log.size();
        do_access(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (rd !== 64'h1234 || to) begin failures++; $display("[TB] FAIL wrap_rdata: got %016h want 1234", rd); end
        checks++;
        if (rd_log.size() - rs != 2) begin
            failures++; $display("[TB] FAIL wrap_count: got %0d want 2", rd_log.size() - rs);
        end else if (rd_log[rs] !== 32'hFFFF_FFFF || rd_log[rs + 1] !== 32'h0) begin
            failures++; $display("[TB] FAIL wrap_addr: got %08h,%08h want ffffffff,00000000", rd_log[rs], rd_log[rs + 1]);
        end
    endtask

    task automatic test_slow_ack();
        int cyc; logic [63:0] rd; logic bf, da, ba, to; int rs, is0, us0, ws;
        logic [63:0] exp_rd;
        for (int i = 0; i < 4; i++) mem[8'h80 + i] = 8'($urandom);
        exp_rd = model_read(32'h80, 4, 1'b0);
        rack_delay = 3;
        rs = rd_log.size(); is0 = issue_cnt; us0 = unstable_cnt;
        do_access(1'b0, 2'b10, 1'b0, 32'h80, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (rd !== exp_rd || to) begin failures++; $display("[TB] FAIL slow_rdata: got %016h want %016h", rd, exp_rd); end
        checks++; if (cyc != 21) begin failures++; $display("[TB] FAIL slow_latency: got %0d want 21", cyc); end
        checks++; if (issue_cnt - is0 != 4 || rd_log.size() - rs != 4) begin failures++; $display("[TB] FAIL slow_issues: got %0d/%0d want 4/4", issue_cnt - is0, rd_log.size() - rs); end
        checks++; if (unstable_cnt != us0) begin failures++; $display("[TB] FAIL slow_stable: got %0d want 0", unstable_cnt - us0); end
        rack_delay = 0;
        wack_delay = 2;
        ws = wr_addr_log.size(); us0 = unstable_cnt;
        do_access(1'b1, 2'b01, 1'b0, 32'h7000_00FF, 64'h5A3C, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (cyc != 9 || to) begin failures++; $display("[TB] FAIL slow_wr_latency: got %0d want 9", cyc); end
        checks++;
        if (wr_addr_log.size() - ws != 2 || unstable_cnt != us0) begin
            failures++; $display("[TB] FAIL slow_wr_count: got %0d unstable=%0d want 2 unstable=0", wr_addr_log.size() - ws, unstable_cnt - us0);
        end else if (wr_data_log[ws] !== 8'h3C || wr_data_log[ws + 1] !== 8'h5A || wr_addr_log[ws + 1] !== 32'h7000_0100) begin
            failures++; $display("[TB] FAIL slow_wr_data: got %02h,%02h@%08h want 3c,5a@70000100", wr_data_log[ws], wr_data_log[ws + 1], wr_addr_log[ws + 1]);
        end
        wack_delay = 0;
    endtask

    task automatic test_reset_mid();
        int cyc; logic [63:0] rd; logic bf, da, ba, to; int ws;
        logic seen;
        ws = wr_addr_log.size();
        @(negedge clk);
        wr = 1'b1; size = 2'b11; sext = 1'b0; addr = 32'h300; wdata = {$urandom, $urandom}; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (we !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre_we: got %0h want 1", we); end
        rst = 1'b1;
        #1;
        checks++; if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async: got we=%0h busy=%0h done=%0h want 0/0/0", we, busy, done); end
        checks++; if (wr_addr_log.size() - ws != 2) begin failures++; $display("[TB] FAIL rstmid_bytes: got %0d want 2", wr_addr_log.size() - ws); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || we || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_quiet: got activity=%0h want 0", seen); end
        mem[8'h40] = 8'h80;
        do_access(1'b0, 2'b00, 1'b0, 32'h40, 64'h0, 1'b0, cyc, rd, bf, da, ba, to);
        checks++; if (rd !== 64'h80 || cyc != 3 || to) begin failures++; $display("[TB] FAIL rstmid_next: got %016h in %0d want 80 in 3", rd, cyc); end
    endtask

    task automatic test_random();
        int cyc; logic [63:0] rd; logic bf, da, ba, to; int rs, ws, is0, n;
        logic w, sx, hold; logic [1:0] sz; logic [31:0] a, ea; logic [63:0] wd, exp_rd;
        logic ok;
        for (int t = 0; t < 24; t++) begin
            w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); sx = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1)); a = $urandom; wd = {$urandom, $urandom};
            if (t < 2) a = 32'hFFFF_FFFC;
            n = 1 << sz;
            for (int i = 0; i < n; i++) begin
                ea = a + 32'(i);
                mem[ea[7:0]] = 8'($urandom);
            end
            exp_rd = w ? 64'h0 : model_read(a, n, sx);
            rs = rd_log.size(); ws = wr_addr_log.size(); is0 = issue_cnt;
            do_access(w, sz, sx, a, wd, hold, cyc, rd, bf, da, ba, to);
            checks++; if (rd !== exp_rd || to) begin failures++; $display("[TB] FAIL rand%0d_rdata: got %016h want %016h", t, rd, exp_rd); end
            checks++; if (cyc != 2 * n + 1 || da !== 1'b0 || ba !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_timing: got %0d done=%0h busy=%0h want %0d 0 0", t, cyc, da, ba, 2 * n + 1); end
            ok = (issue_cnt - is0 == n);
            if (w) begin
                ok = ok && (wr_addr_log.size() - ws == n) && (rd_log.size() == rs);
                for (int i = 0; i < n && ws + i < wr_addr_log.size(); i++)
                    if (wr_addr_log[ws + i] !== a + 32'(i) || wr_data_log[ws + i] !== 8'(wd >> (8 * i))) ok = 1'b0;
            end else begin
                ok = ok && (rd_log.size() - rs == n) && (wr_addr_log.size() == ws);
                for (int i = 0; i < n && rs + i < rd_log.size(); i++)
                    if (rd_log[rs + i] !== a + 32'(i)) ok = 1'b0;
            end
            checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rand%0d_bytes: got issues=%0d want %0d in order from %08h", t, issue_cnt - is0, n, a); end
        end
        checks++; if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
    endtask

    initial begin
        req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_read8();
        test_write4();
        test_sext();
        test_wrap();
        test_slow_ack();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter MADDR_SZ, default 32, byte-address width toward memory.
REQ-002 SHALL have parameter DATA_SZ, default 64, CPU-side data width in bits (8 bytes max per access).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  1  CPU access request, sampled only in IDLE.
REQ-006 SHALL have port wr  input  1  1=write, 0=read; sampled with req.
REQ-007 SHALL have port size  input  2  bytes per access: 00=1, 01=2, 10=4, 11=8; sampled with req.
REQ-008 SHALL have port sext  input  1  read sign-extension enable; sampled with req.
REQ-009 SHALL have port addr  input  MADDR_SZ  start byte address; sampled with req.
REQ-010 SHALL have port wdata  input  DATA_SZ  write data, little-endian, byte 0 = wdata[7:0]; sampled with req.
REQ-011 SHALL have port rdata  output  DATA_SZ  assembled read data, valid while done=1.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high from request acceptance until done pulse.
REQ-014 SHALL have ports raddr/waddr  output  MADDR_SZ  memory byte addresses.
REQ-015 SHALL have ports re/we  output  1  memory read/write strobes (level, four-phase).
REQ-016 SHALL have port datain  output  8  memory write byte; port dataout  input  8  memory read byte.
REQ-017 SHALL have ports rack/wack  input  1  memory acknowledges.

Function
REQ-018 SHALL be the initiator of the four-phase byte handshake: raise strobe, wait ack=1, drop strobe, wait ack=0.
REQ-019 SHALL use FSM states IDLE, ACCESS, RELEASE, DONE.
REQ-020 SHALL, in IDLE with req=1, latch wr/size/sext/addr/wdata, clear byte index idx=0 and rdata, set busy, go ACCESS with the strobe (re or we) registered high.
REQ-021 SHALL, in ACCESS, hold strobe high and raddr/waddr = addr+idx, datain = wdata byte idx, all stable until ack=1 is seen.
REQ-022 SHALL, in ACCESS on ack=1, capture dataout into rdata byte idx (read), drop the strobe, go RELEASE.
REQ-023 SHALL, in RELEASE on ack=0, go DONE if idx = N-1, else increment idx and return to ACCESS with strobe high.
REQ-024 SHALL, in DONE, assert done and present rdata for exactly one cycle, then clear busy and go IDLE.
REQ-025 SHALL sign-extend rdata from bit 8N-1 when sext=1 and wr=0, else zero-extend; rdata is 0 for writes.
REQ-026 SHALL issue bytes in ascending address order; address arithmetic SHALL wrap modulo 2^MADDR_SZ; no alignment requirement.
REQ-027 SHALL ignore req while busy=1; never assert re and we simultaneously.
REQ-028 SHALL, with a zero-delay memory, complete an N-byte access in 2N+1 cycles from the accepting edge to the done cycle.
REQ-029 SHALL wait indefinitely for ack (no timeout).

Reset
REQ-030 SHALL on rst drive immediately re=0, we=0, done=0, busy=0, rdata=0, raddr=0, waddr=0, datain=0, idx=0, state IDLE.
REQ-031 SHALL abort any in-flight access on rst without a done pulse; the next req after rst deasserts starts a fresh access.

Structure
REQ-032 SHALL place size encodings, FSM state encodings and the byte-count function (size -> N) in shared package mem_pkg.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL test: read size=11 at 0x10, memory bytes 01..08 -> rdata=0x0807060504030201, done in cycle 17 after the accepting edge.
REQ-035 SHALL test: write size=10 at 0x205, wdata=0xDEADBEEF -> bytes EF,BE,AD,DE written at 0x205..0x208 in order.
REQ-036 SHALL test: read size=00 sext=1 of byte 0x80 -> rdata=0xFFFFFFFFFFFFFF80; sext=0 -> 0x80.
REQ-037 SHALL test: read size=01 at 0xFFFFFFFF -> accesses 0xFFFFFFFF then 0x00000000.
REQ-038 SHALL test: memory delaying rack by 3 cycles -> raddr/re held stable, no extra byte issued, correct rdata.
REQ-039 SHALL test: rst asserted mid 8-byte write -> we falls in the same cycle, no done, and a following 1-byte read completes normally.
